// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the ALU control decoder and the iterative multiply/divide unit.
package alu_control_mdu_pkg;

  localparam int unsigned FUNCT_WIDTH = 6;

  // Non-R-type ALUOp class codes
  localparam int unsigned ALUOP_ADDI = 0;
  localparam int unsigned ALUOP_ORI  = 1;
  localparam int unsigned ALUOP_LUI  = 2;
  localparam int unsigned ALUOP_ANDI = 3;
  localparam int unsigned ALUOP_BEQ  = 4;
  localparam int unsigned ALUOP_LW   = 5;
  localparam int unsigned ALUOP_SW   = 6;

  localparam logic [FUNCT_WIDTH-1:0] FN_AND   = 6'b100100;
  localparam logic [FUNCT_WIDTH-1:0] FN_OR    = 6'b100101;
  localparam logic [FUNCT_WIDTH-1:0] FN_NOR   = 6'b100111;
  localparam logic [FUNCT_WIDTH-1:0] FN_ADD   = 6'b100000;
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB   = 6'b100010;
  localparam logic [FUNCT_WIDTH-1:0] FN_SLL   = 6'b000000;
  localparam logic [FUNCT_WIDTH-1:0] FN_SRL   = 6'b000010;
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT   = 6'b101010;
  localparam logic [FUNCT_WIDTH-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FUNCT_WIDTH-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FUNCT_WIDTH-1:0] FN_MULT  = 6'b011000;
  localparam logic [FUNCT_WIDTH-1:0] FN_MULTU = 6'b011001;
  localparam logic [FUNCT_WIDTH-1:0] FN_DIV   = 6'b011010;
  localparam logic [FUNCT_WIDTH-1:0] FN_DIVU  = 6'b011011;

  localparam logic [3:0] OPC_AND  = 4'b0000;
  localparam logic [3:0] OPC_OR   = 4'b0001;
  localparam logic [3:0] OPC_NOR  = 4'b0010;
  localparam logic [3:0] OPC_ADD  = 4'b0011;
  localparam logic [3:0] OPC_SUB  = 4'b0100;
  localparam logic [3:0] OPC_LUI  = 4'b0101;
  localparam logic [3:0] OPC_SLL  = 4'b0110;
  localparam logic [3:0] OPC_SRL  = 4'b0111;
  localparam logic [3:0] OPC_SLT  = 4'b1000;
  localparam logic [3:0] OPC_BAD  = 4'b1001;
  localparam logic [3:0] OPC_MFHI = 4'b1010;
  localparam logic [3:0] OPC_MFLO = 4'b1011;
  localparam logic [3:0] OPC_PASS = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU occupy 011000..011011
  function automatic logic is_mdu_funct(input logic [FUNCT_WIDTH-1:0] fn);
    return fn[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_control_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, followed by a sign-fix cycle that writes HI/LO.
module alu_control_mdu_iter
  import alu_control_mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_div,
  input  logic                  op_signed,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  mdu_state_e     state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  // acc: partial product high half / remainder; sh: multiplier / quotient
  logic [W-1:0]   acc, acc_d, sh, sh_d, opnd, opnd_d;
  logic           is_div, is_div_d, neg_lo, neg_lo_d, neg_hi, neg_hi_d;
  logic [W-1:0]   hi_d, lo_d;
  logic           busy_d, done_d;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     sum, diff;

  always_comb begin
    mag_a = (op_signed && src_a[W-1]) ? -src_a : src_a;
    mag_b = (op_signed && src_b[W-1]) ? -src_b : src_b;
    sum   = {1'b0, acc} + {1'b0, opnd};
    diff  = {acc, sh[W-1]} - {1'b0, opnd};
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_d    = acc;
    sh_d     = sh;
    opnd_d   = opnd;
    is_div_d = is_div;
    neg_lo_d = neg_lo;
    neg_hi_d = neg_hi;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          is_div_d = op_div;
          cnt_d    = '0;
          if (op_div && (src_b == '0)) begin
            // divide by zero skips the iterations and lands the fixed result in FIX
            acc_d    = src_a;
            sh_d     = '1;
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d  = S_FIX;
          end else begin
            acc_d    = '0;
            sh_d     = op_div ? mag_a : mag_b;
            opnd_d   = op_div ? mag_b : mag_a;
            neg_lo_d = op_signed & (src_a[W-1] ^ src_b[W-1]);
            neg_hi_d = op_signed & src_a[W-1];
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (is_div) begin
          if (!diff[W]) begin
            acc_d = diff[W-1:0];
            sh_d  = {sh[W-2:0], 1'b1};
          end else begin
            acc_d = {acc[W-2:0], sh[W-1]};
            sh_d  = {sh[W-2:0], 1'b0};
          end
        end else if (sh[0]) begin
          {acc_d, sh_d} = {sum, sh[W-1:1]};
        end else begin
          {acc_d, sh_d} = {1'b0, acc, sh[W-1:1]};
        end
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div) begin
          lo_d = neg_lo ? -sh : sh;
          hi_d = neg_hi ? -acc : acc;
        end else begin
          {hi_d, lo_d} = neg_lo ? -{acc, sh} : {acc, sh};
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      acc    <= acc_d;
      sh     <= sh_d;
      opnd   <= opnd_d;
      is_div <= is_div_d;
      neg_lo <= neg_lo_d;
      neg_hi <= neg_hi_d;
      hi     <= hi_d;
      lo     <= lo_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an attached iterative multiply/divide unit and its hazard stall.
module alu_control_mdu
  import alu_control_mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ALUOP_WIDTH = 3,
  parameter int unsigned OP_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic [DATA_WIDTH-1:0]  src_a,
  input  logic [DATA_WIDTH-1:0]  src_b,
  output logic [OP_WIDTH-1:0]    ALUOperation,
  output logic [DATA_WIDTH-1:0]  hi,
  output logic [DATA_WIDTH-1:0]  lo,
  output logic                   mdu_busy,
  output logic                   mdu_done,
  output logic                   stall
);

  logic       rtype, mdu_op, mf_op, start;
  logic [3:0] op_c;

  assign rtype  = (ALUOp == {ALUOP_WIDTH{1'b1}});
  assign mdu_op = rtype & is_mdu_funct(ALUFunction);
  assign mf_op  = rtype & ((ALUFunction == FN_MFHI) | (ALUFunction == FN_MFLO));
  assign stall  = issue_valid & (mdu_op | mf_op) & mdu_busy;
  assign start  = issue_valid & mdu_op & ~stall;

  // Operation decode
  always_comb begin
    op_c = OPC_BAD;
    if (rtype) begin
      case (ALUFunction)
        FN_AND:  op_c = OPC_AND;
        FN_OR:   op_c = OPC_OR;
        FN_NOR:  op_c = OPC_NOR;
        FN_ADD:  op_c = OPC_ADD;
        FN_SUB:  op_c = OPC_SUB;
        FN_SLL:  op_c = OPC_SLL;
        FN_SRL:  op_c = OPC_SRL;
        FN_SLT:  op_c = OPC_SLT;
        FN_MFHI: op_c = OPC_MFHI;
        FN_MFLO: op_c = OPC_MFLO;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: op_c = OPC_PASS;
        default: op_c = OPC_BAD;
      endcase
    end else begin
      case (ALUOp)
        ALUOP_WIDTH'(ALUOP_ADDI): op_c = OPC_ADD;
        ALUOP_WIDTH'(ALUOP_ORI):  op_c = OPC_OR;
        ALUOP_WIDTH'(ALUOP_LUI):  op_c = OPC_LUI;
        ALUOP_WIDTH'(ALUOP_ANDI): op_c = OPC_AND;
        ALUOP_WIDTH'(ALUOP_BEQ):  op_c = OPC_SUB;
        ALUOP_WIDTH'(ALUOP_LW):   op_c = OPC_ADD;
        ALUOP_WIDTH'(ALUOP_SW):   op_c = OPC_ADD;
        default:                  op_c = OPC_BAD;
      endcase
    end
  end

  assign ALUOperation = OP_WIDTH'(op_c);

  alu_control_mdu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_div   (ALUFunction[1]),
    .op_signed(~ALUFunction[0]),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi       (hi),
    .lo       (lo),
    .busy     (mdu_busy),
    .done     (mdu_done)
  );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MULT/DIV results and latency, stalls, reset abort.
module tb_alu_control_mdu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         issue_valid;
  logic [2:0]   ALUOp;
  logic [5:0]   ALUFunction;
  logic [W-1:0] src_a, src_b;
  logic [3:0]   ALUOperation;
  logic [W-1:0] hi, lo;
  logic         mdu_busy, mdu_done, stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]   fn;
    logic [W-1:0] a, b, hi, lo;
    int           busy_n;
    int           done_at;
  } vec_t;

  alu_control_mdu #(.DATA_WIDTH(W), .ALUOP_WIDTH(3), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .ALUOp(ALUOp),
    .ALUFunction(ALUFunction), .src_a(src_a), .src_b(src_b),
    .ALUOperation(ALUOperation), .hi(hi), .lo(lo), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = 3'b111; ALUFunction = fn; src_a = a; src_b = b; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  // Issues one op and records busy cycles, first done cycle and done count over 40 cycles
  task automatic run_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_n, output int done_at, output int done_n);
    busy_n = 0; done_at = 0; done_n = 0;
    issue(fn, a, b);
    for (int k = 1; k <= 40; k++) begin
      if (mdu_busy) busy_n++;
      if (mdu_done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; ALUOp = 3'b000; ALUFunction = 6'b0;
    src_a = '0; src_b = '0;
    tick(); tick();
    ALUOp = 3'b111; ALUFunction = 6'b010000; issue_valid = 1'b1;
    #1;
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mdu_busy); end
    total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", mdu_done); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    issue_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    logic [5:0] fn_tab [16];
    logic [3:0] fn_exp [16];
    logic [3:0] aop_exp [7];
    fn_tab = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000, 6'b000010,
               6'b101010, 6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
               6'b111111, 6'b100001};
    fn_exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB,
               4'hC, 4'hC, 4'hC, 4'hC, 4'h9, 4'h9};
    aop_exp = '{4'h3, 4'h1, 4'h5, 4'h0, 4'h4, 4'h3, 4'h3};
    issue_valid = 1'b0;
    ALUOp = 3'b111;
    for (int i = 0; i < 16; i++) begin
      ALUFunction = fn_tab[i];
      #1;
      total++;
      if (ALUOperation !== fn_exp[i]) begin
        bad++; $display("FAIL decode_rtype funct=%b got=%h exp=%h", fn_tab[i], ALUOperation, fn_exp[i]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      ALUOp = 3'(i);
      ALUFunction = 6'b100111;
      #1;
      total++;
      if (ALUOperation !== aop_exp[i]) begin
        bad++; $display("FAIL decode_aluop aluop=%0d got=%h exp=%h", i, ALUOperation, aop_exp[i]);
      end
    end
    tick();
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL decode_no_start busy=%b exp=0", mdu_busy); end
  endtask

  task automatic test_mdu_vectors();
    vec_t v [9];
    int busy_n, done_at, done_n;
    v[0] = '{6'b011000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 34};
    v[1] = '{6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 34};
    v[2] = '{6'b011000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 34};
    v[3] = '{6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 34};
    v[4] = '{6'b011010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 34};
    v[5] = '{6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 34};
    v[6] = '{6'b011011, 32'd100,      32'd7,        32'd2,        32'd14,       33, 34};
    v[7] = '{6'b011011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1, 2};
    v[8] = '{6'b011010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 2};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].fn, v[i].a, v[i].b, busy_n, done_at, done_n);
      total++; if (busy_n !== v[i].busy_n) begin bad++; $display("FAIL mdu_busy_len vec=%0d got=%0d exp=%0d", i, busy_n, v[i].busy_n); end
      total++; if (done_at !== v[i].done_at) begin bad++; $display("FAIL mdu_done_cycle vec=%0d got=%0d exp=%0d", i, done_at, v[i].done_at); end
      total++; if (done_n !== 1) begin bad++; $display("FAIL mdu_done_count vec=%0d got=%0d exp=1", i, done_n); end
      total++; if (hi !== v[i].hi) begin bad++; $display("FAIL mdu_hi vec=%0d got=%h exp=%h", i, hi, v[i].hi); end
      total++; if (lo !== v[i].lo) begin bad++; $display("FAIL mdu_lo vec=%0d got=%h exp=%h", i, lo, v[i].lo); end
    end
  endtask

  // MFLO held from cycle 5 of a MULTU, with an ADD slipped in at cycle 10
  task automatic test_stall();
    logic exp_stall;
    issue(6'b011001, 32'd5, 32'd6);
    for (int k = 1; k <= 36; k++) begin
      if (k >= 5) begin
        ALUOp = 3'b111;
        ALUFunction = (k == 10) ? 6'b100000 : 6'b010010;
        issue_valid = 1'b1;
      end
      #1;
      exp_stall = (k >= 5) && (k <= 33) && (k != 10);
      total++; if (stall !== exp_stall) begin bad++; $display("FAIL stall cycle=%0d got=%b exp=%b", k, stall, exp_stall); end
      if (k == 10) begin
        total++; if (ALUOperation !== 4'h3) begin bad++; $display("FAIL stall_add_op got=%h exp=3", ALUOperation); end
      end
      tick();
    end
    issue_valid = 1'b0;
    total++; if (lo !== 32'd30 || hi !== 32'd0) begin bad++; $display("FAIL stall_result got=%h_%h exp=0_1e", hi, lo); end
  endtask

  task automatic test_reset_mid_run();
    int seen_done, seen_busy;
    seen_done = 0; seen_busy = 0;
    issue(6'b011000, 32'd3, 32'd4);
    for (int k = 1; k < 10; k++) tick();
    total++; if (mdu_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", mdu_busy); end
    #2 reset = 1'b1;
    #1;
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL abort_hilo got=%h exp=0", {hi, lo}); end
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", mdu_busy); end
    total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", mdu_done); end
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mdu_done) seen_done++;
      if (mdu_busy) seen_busy++;
      tick();
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    total++; if (seen_busy !== 0) begin bad++; $display("FAIL abort_no_busy got=%0d exp=0", seen_busy); end
  endtask

  // Second MULTU presented during FIX of the first
  task automatic test_back_to_back();
    int busy_n, done_at, done_n;
    busy_n = 0; done_at = 0; done_n = 0;
    issue(6'b011001, 32'hFFFFFFFF, 32'd2);
    for (int k = 1; k < 33; k++) tick();
    ALUOp = 3'b111; ALUFunction = 6'b011001; src_a = 32'h00010000; src_b = 32'h00010000;
    issue_valid = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall_fix got=%b exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall_idle got=%b exp=0", stall); end
    total++; if (mdu_done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", mdu_done); end
    total++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin bad++; $display("FAIL b2b_first_result got=%h exp=00000001fffffffe", {hi, lo}); end
    tick();
    issue_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (mdu_busy) busy_n++;
      if (mdu_done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      tick();
    end
    total++; if (busy_n !== 33) begin bad++; $display("FAIL b2b_second_busy got=%0d exp=33", busy_n); end
    total++; if (done_at !== 34 || done_n !== 1) begin bad++; $display("FAIL b2b_second_done at=%0d n=%0d exp at=34 n=1", done_at, done_n); end
    total++; if ({hi, lo} !== 64'h00000001_00000000) begin bad++; $display("FAIL b2b_second_result got=%h exp=0000000100000000", {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mdu_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
